regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between the in-order pipeline WB stage
//  and a long-latency unit (multicycle mul/div, non-blocking load return).
//  Pipeline WB has priority; the long-latency result waits in a 1-entry holding buffer.
//  Starvation is bounded by a wait counter that briefly stalls the pipeline.
//  Pending-write hit flags go to the hazard unit. Sits between WB/MC units and RegFile.
// PARAMETERS
//  WORD_LEN   32  data width
//  REG_IDX_W  5   register index width
//  ADDR_SIZE  32  PC width (carried for the RegFile write trace)
//  MAX_WAIT   4   pipeline-won cycles a held result tolerates before a forced drain (>=1)
// PORTS
//  clk          in   1          clock; all state on posedge
//  rstn         in   1          async active-low reset
//  pipe_we      in   1          WB-stage write request
//  pipe_waddr   in   REG_IDX_W  WB destination
//  pipe_wdata   in   WORD_LEN   WB data
//  pipe_pc      in   ADDR_SIZE  WB instruction PC
//  mc_valid     in   1          long-latency result valid
//  mc_ready     out  1          buffer can accept (= !buf_valid)
//  mc_waddr     in   REG_IDX_W  long-latency destination
//  mc_wdata     in   WORD_LEN   long-latency data
//  mc_pc        in   ADDR_SIZE  long-latency instruction PC
//  rd_addr1     in   REG_IDX_W  decode source 1 (hazard check)
//  rd_addr2     in   REG_IDX_W  decode source 2 (hazard check)
//  pend_hit     out  1          source matches held buffer dest (non-zero)
//  stall_pipe   out  1          freeze WB and earlier stages this cycle
//  buf_kill     out  1          1-cycle pulse: held result discarded (WAW)
//  rf_we        out  1          to RegFile writeEnable
//  rf_waddr     out  REG_IDX_W  to RegFile writeAddr
//  rf_wdata     out  WORD_LEN   to RegFile writeData
//  rf_pc        out  ADDR_SIZE  to RegFile pc_WB
// BEHAVIOUR
//  - rf_* combinational from current inputs + state; RegFile commits at negedge same cycle.
//  - Reset: state IDLE, buf_valid=0, wait_cnt=0, buf_kill=0; thus mc_ready=1, stall_pipe=0,
//    pend_hit=0, rf_* follow pipe_*. Reset mid-hold drops the held result (not written).
//  - pw = pipe_we && pipe_waddr!=0 (effective pipe write).
//  - Accept: posedge with mc_valid && mc_ready -> buffer loads {waddr,wdata,pc}, state HELD.
//    mc_waddr==0 accepted (handshake completes) but discarded; state stays IDLE.
//  - IDLE: rf_* = pipe_*, rf_we = pw.
//  - HELD, pw=0: drain - rf_* = buffer, rf_we=1; posedge -> IDLE, buf_valid=0, wait_cnt=0.
//  - HELD, pw=1, pipe_waddr!=buf_waddr: pipe wins; wait_cnt+1; if new count==MAX_WAIT -> FORCE.
//  - HELD, pw=1, pipe_waddr==buf_waddr: pipe wins (younger); buffer dropped, buf_kill=1
//    next cycle, -> IDLE, wait_cnt=0.
//  - FORCE (exactly 1 cycle): stall_pipe=1, pipe_* ignored, rf_* = buffer, rf_we=1;
//    posedge -> IDLE, wait_cnt=0. Pipeline re-presents same WB next cycle.
//  - mc_ready registered-only: no accept in the drain cycle; next accept >=1 cycle later.
//  - pend_hit = buf_valid && ((rd_addr1==buf_waddr)||(rd_addr2==buf_waddr)); never on x0.
//  - wait_cnt width $clog2(MAX_WAIT+1); saturates by construction (FORCE resets it).
//  - Write order per register preserved; no result written twice; x0 never written.
// TESTING
//  1 Reset: rstn=0 -> mc_ready=1, stall_pipe=0, pend_hit=0; pipe_we=1 x5=0x11 -> rf_we=1, x5=0x11.
//  2 mc x7=0xAB with pipe idle -> HELD next cycle, pend_hit for rd_addr1=7, rf writes x7=0xAB cycle after.
//  3 Hold x7, pipe writes x1..x4 in 4 back-to-back cycles (MAX_WAIT=4) -> 5th cycle stall_pipe=1,
//    rf x7=0xAB; next cycle pipe x5 written, stall_pipe=0.
//  4 Hold x9=0x1, pipe writes x9=0x2 -> rf x9=0x2, buf_kill pulses once, x9 never gets 0x1.
//  5 mc_valid with waddr=0 -> accepted, mc_ready stays 1, no rf write, pend_hit=0.
//  6 rstn low while holding x3=0x55 -> buffer cleared; after release no write of x3, mc_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-port sharing bus: the WB-stage and long-latency write requests, the
// decode-stage hazard probe, and the merged RegFile write port.
interface regfile_wb_arbiter_if #(
  parameter int WORD_LEN  = 32,
  parameter int REG_IDX_W = 5,
  parameter int ADDR_SIZE = 32
);
  // pipeline WB stage
  logic                 pipe_we;
  logic [REG_IDX_W-1:0] pipe_waddr;
  logic [WORD_LEN-1:0]  pipe_wdata;
  logic [ADDR_SIZE-1:0] pipe_pc;
  // long-latency unit
  logic                 mc_valid;
  logic                 mc_ready;
  logic [REG_IDX_W-1:0] mc_waddr;
  logic [WORD_LEN-1:0]  mc_wdata;
  logic [ADDR_SIZE-1:0] mc_pc;
  // hazard unit
  logic [REG_IDX_W-1:0] rd_addr1;
  logic [REG_IDX_W-1:0] rd_addr2;
  logic                 pend_hit;
  logic                 stall_pipe;
  logic                 buf_kill;
  // RegFile write port
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [WORD_LEN-1:0]  rf_wdata;
  logic [ADDR_SIZE-1:0] rf_pc;

  // Producer side: WB stage, long-latency unit, decode, and observers.
  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    output mc_valid, mc_waddr, mc_wdata, mc_pc,
    output rd_addr1, rd_addr2,
    input  mc_ready, pend_hit, stall_pipe, buf_kill,
    input  rf_we, rf_waddr, rf_wdata, rf_pc
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    input  mc_valid, mc_waddr, mc_wdata, mc_pc,
    input  rd_addr1, rd_addr2,
    output mc_ready, pend_hit, stall_pipe, buf_kill,
    output rf_we, rf_waddr, rf_wdata, rf_pc
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single RegFile write port between the in-order WB stage and a
// long-latency result held in a 1-entry buffer. WB wins by default; the held
// result drains on idle WB cycles, or is forced through after MAX_WAIT lost
// cycles by stalling the pipeline for one cycle. A younger WB write to the same
// register kills the held result so write order per register is preserved.
module regfile_wb_arbiter #(
  parameter int WORD_LEN  = 32,
  parameter int REG_IDX_W = 5,
  parameter int ADDR_SIZE = 32,
  parameter int MAX_WAIT  = 4
) (
  input logic                 clk,
  input logic                 rstn,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, HELD, FORCE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic                 r_buf_kill, w_kill_nxt;
  logic [REG_IDX_W-1:0] r_buf_waddr;
  logic [WORD_LEN-1:0]  r_buf_wdata;
  logic [ADDR_SIZE-1:0] r_buf_pc;

  logic                 w_pw, w_buf_valid, w_load, w_same_dst;
  logic                 w_stall, w_rf_we;
  logic [REG_IDX_W-1:0] w_rf_waddr;
  logic [WORD_LEN-1:0]  w_rf_wdata;
  logic [ADDR_SIZE-1:0] w_rf_pc;

  // Effective pipe write, buffer occupancy and accept qualification.
  always_comb begin
    w_pw        = bus.pipe_we && (bus.pipe_waddr != '0);
    w_buf_valid = (r_state != IDLE);
    // x0 results complete the handshake but never occupy the buffer
    w_load      = bus.mc_valid && !w_buf_valid && (bus.mc_waddr != '0);
    w_same_dst  = (bus.pipe_waddr == r_buf_waddr);
    w_wait_inc  = r_wait_cnt + CW'(1);
  end

  // Next state, wait counter and write-port mux.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_kill_nxt  = 1'b0;
    w_stall     = 1'b0;
    w_rf_we     = w_pw;
    w_rf_waddr  = bus.pipe_waddr;
    w_rf_wdata  = bus.pipe_wdata;
    w_rf_pc     = bus.pipe_pc;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_nxt = HELD;
      end
      HELD: begin
        if (!w_pw) begin
          // WB idle: drain the held result
          w_rf_we     = 1'b1;
          w_rf_waddr  = r_buf_waddr;
          w_rf_wdata  = r_buf_wdata;
          w_rf_pc     = r_buf_pc;
          w_state_nxt = IDLE;
          w_wait_nxt  = '0;
        end else if (w_same_dst) begin
          // younger WB write supersedes the held one
          w_kill_nxt  = 1'b1;
          w_state_nxt = IDLE;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == CW'(MAX_WAIT)) w_state_nxt = FORCE;
        end
      end
      FORCE: begin
        // pipeline frozen; it re-presents the same WB next cycle
        w_stall     = 1'b1;
        w_rf_we     = 1'b1;
        w_rf_waddr  = r_buf_waddr;
        w_rf_wdata  = r_buf_wdata;
        w_rf_pc     = r_buf_pc;
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Control state: FSM, wait counter, kill pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_buf_kill <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_buf_kill <= w_kill_nxt;
    end
  end

  // Holding buffer payload, captured on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_waddr <= '0;
      r_buf_wdata <= '0;
      r_buf_pc    <= '0;
    end else if (w_load) begin
      r_buf_waddr <= bus.mc_waddr;
      r_buf_wdata <= bus.mc_wdata;
      r_buf_pc    <= bus.mc_pc;
    end
  end

  assign bus.mc_ready   = !w_buf_valid;
  assign bus.pend_hit   = w_buf_valid && (r_buf_waddr != '0) &&
                          ((bus.rd_addr1 == r_buf_waddr) || (bus.rd_addr2 == r_buf_waddr));
  assign bus.stall_pipe = w_stall;
  assign bus.buf_kill   = r_buf_kill;
  assign bus.rf_we      = w_rf_we;
  assign bus.rf_waddr   = w_rf_waddr;
  assign bus.rf_wdata   = w_rf_wdata;
  assign bus.rf_pc      = w_rf_pc;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench: stimulus pushes the RegFile writes it expects for the
// current cycle; a monitor pops and compares at every negedge and flags both
// unexpected and missing writes. Handshake/hazard flags are checked inline.
module tb_regfile_wb_arbiter;
  localparam int WL = 32, RW = 5, AS = 32, MW = 4;

  typedef struct {
    logic [RW-1:0] a;
    logic [WL-1:0] d;
    logic [AS-1:0] pc;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  wr_t  q[$];
  bit   done = 1'b0;

  regfile_wb_arbiter_if #(.WORD_LEN(WL), .REG_IDX_W(RW), .ADDR_SIZE(AS)) bus ();

  regfile_wb_arbiter #(.WORD_LEN(WL), .REG_IDX_W(RW), .ADDR_SIZE(AS), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0; bus.pipe_pc = 0;
    bus.mc_valid = 0; bus.mc_waddr = 0; bus.mc_wdata = 0; bus.mc_pc = 0;
    bus.rd_addr1 = 0; bus.rd_addr2 = 0;
  endtask

  task automatic pipe(input logic [RW-1:0] a, input logic [WL-1:0] d, input logic [AS-1:0] pc);
    bus.pipe_we = 1; bus.pipe_waddr = a; bus.pipe_wdata = d; bus.pipe_pc = pc;
  endtask

  task automatic mc(input logic [RW-1:0] a, input logic [WL-1:0] d, input logic [AS-1:0] pc);
    bus.mc_valid = 1; bus.mc_waddr = a; bus.mc_wdata = d; bus.mc_pc = pc;
  endtask

  task automatic exp_wr(input logic [RW-1:0] a, input logic [WL-1:0] d, input logic [AS-1:0] pc);
    wr_t e;
    e.a = a; e.d = d; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b at %0t", name, got, exp, $time);
    end
  endtask

  // Checks flags at the negedge of the current cycle: ready, stall, pend, kill.
  task automatic flags(input string name, input logic rdy, input logic stl,
                       input logic pnd, input logic kil);
    @(negedge clk);
    chk({name, ".mc_ready"},   bus.mc_ready,   rdy);
    chk({name, ".stall_pipe"}, bus.stall_pipe, stl);
    chk({name, ".pend_hit"},   bus.pend_hit,   pnd);
    chk({name, ".buf_kill"},   bus.buf_kill,   kil);
  endtask

  // Monitor: every write must match the head of the queue; an expected write
  // that does not appear in its cycle is reported and dropped.
  always @(negedge clk) begin
    if (!done) begin
      if (bus.rf_we === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rf_write unexpected got x%0d=0x%0h pc=0x%0h", bus.rf_waddr, bus.rf_wdata, bus.rf_pc);
        end else begin
          wr_t e;
          e = q.pop_front();
          if (bus.rf_waddr !== e.a || bus.rf_wdata !== e.d || bus.rf_pc !== e.pc) begin
            failures++;
            $display("FAIL rf_write got x%0d=0x%0h pc=0x%0h exp x%0d=0x%0h pc=0x%0h",
                     bus.rf_waddr, bus.rf_wdata, bus.rf_pc, e.a, e.d, e.pc);
          end
        end
      end else if (q.size() != 0) begin
        wr_t e;
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL rf_write missing got rf_we=%0b exp x%0d=0x%0h pc=0x%0h", bus.rf_we, e.a, e.d, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // 1: reset state, WB passes straight through
    nxt();
    pipe(5, 32'h11, 32'h100); exp_wr(5, 32'h11, 32'h100);
    flags("t1_reset", 1, 0, 0, 0);
    nxt(); idle(); rstn = 1;
    flags("t1_idle", 1, 0, 0, 0);

    // x0 pipe write must not reach the RegFile
    nxt(); pipe(0, 32'hDEAD, 32'h104);
    flags("t1_x0", 1, 0, 0, 0);

    // 2: mc x7 accepted while WB idle, drains the following cycle
    nxt(); idle(); mc(7, 32'hAB, 32'h200);
    flags("t2_accept", 1, 0, 0, 0);
    nxt(); idle(); bus.rd_addr1 = 7; exp_wr(7, 32'hAB, 32'h200);
    flags("t2_held", 0, 0, 1, 0);
    nxt(); bus.rd_addr1 = 7;
    flags("t2_after", 1, 0, 0, 0);

    // 3: starvation bound, forced drain after MAX_WAIT lost cycles
    nxt(); idle(); mc(7, 32'hAB, 32'h300);
    flags("t3_accept", 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); idle();
      pipe(RW'(i), 32'h10 + i, 32'h400 + i); exp_wr(RW'(i), 32'h10 + i, 32'h400 + i);
      flags($sformatf("t3_lose%0d", i), 0, 0, 0, 0);
    end
    nxt(); pipe(5, 32'h15, 32'h405); exp_wr(7, 32'hAB, 32'h300);
    flags("t3_force", 0, 1, 0, 0);
    nxt(); pipe(5, 32'h15, 32'h405); exp_wr(5, 32'h15, 32'h405);
    flags("t3_resume", 1, 0, 0, 0);

    // 4: WAW, younger WB write kills held x9
    nxt(); idle(); mc(9, 32'h1, 32'h500);
    flags("t4_accept", 1, 0, 0, 0);
    nxt(); idle(); pipe(9, 32'h2, 32'h600); exp_wr(9, 32'h2, 32'h600);
    flags("t4_waw", 0, 0, 0, 0);
    nxt(); idle();
    flags("t4_kill", 1, 0, 0, 1);
    nxt();
    flags("t4_nokill", 1, 0, 0, 0);

    // 5: x0 long-latency result accepted and discarded
    nxt(); mc(0, 32'h77, 32'h700);
    flags("t5_accept", 1, 0, 0, 0);
    nxt(); idle();
    flags("t5_after", 1, 0, 0, 0);

    // 6: reset while holding x3 drops it
    nxt(); mc(3, 32'h55, 32'h800);
    flags("t6_accept", 1, 0, 0, 0);
    nxt(); idle(); pipe(8, 32'h88, 32'h900); bus.rd_addr2 = 3; exp_wr(8, 32'h88, 32'h900);
    flags("t6_held", 0, 0, 1, 0);
    #1 rstn = 0;
    nxt(); idle(); bus.rd_addr2 = 3;
    flags("t6_inreset", 1, 0, 0, 0);
    nxt(); rstn = 1;
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.rd_addr2 = 3;
      flags($sformatf("t6_post%0d", i), 1, 0, 0, 0);
    end

    nxt();
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
